// File: rtl/vga_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_scan_ctrl
// Brief    : 640x480@60 Hz VGA scan controller: 25 MHz tick from CLOCK_50,
//            scan position publish, latency-aligned RGB/sync output, frame pulse.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_ctrl #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int RENDER_LAT = 1
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    output logic [9:0] PIX_X,
    output logic [9:0] PIX_Y,
    output logic       PIX_REQ,
    input  logic [7:0] PIX_R,
    input  logic [7:0] PIX_G,
    input  logic [7:0] PIX_B,
    output logic       FRAME_START,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam logic [9:0] C_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] C_H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] C_HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] C_HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] C_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] C_V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] C_VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] C_VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam int         C_PW       = 3 * RENDER_LAT;
    // Each pipe stage holds {hs_n, vs_n, vis}; idle value is syncs inactive, blanked.
    localparam logic [C_PW-1:0] C_PIPE_RST = {RENDER_LAT{3'b110}};

    logic            r_phase_q, w_phase_d, w_tick;
    logic [9:0]      r_h_cnt_q, w_h_cnt_d;
    logic [9:0]      r_v_cnt_q, w_v_cnt_d;
    logic            w_vis, w_hs_n, w_vs_n;
    logic [2:0]      w_dec, w_pipe_out;
    logic [C_PW-1:0] r_pipe_q, w_pipe_d, w_pipe_shift;
    logic            r_hs_q, w_hs_d;
    logic            r_vs_q, w_vs_d;
    logic            r_blank_n_q, w_blank_n_d;
    logic            r_frame_start_q, w_frame_start_d;
    logic [7:0]      r_r_q, w_r_d;
    logic [7:0]      r_g_q, w_g_d;
    logic [7:0]      r_b_q, w_b_d;

    assign w_tick     = r_phase_q;
    assign w_vis      = (r_h_cnt_q < C_H_VIS) && (r_v_cnt_q < C_V_VIS);
    assign w_hs_n     = !((r_h_cnt_q >= C_HS_FIRST) && (r_h_cnt_q <= C_HS_LAST));
    assign w_vs_n     = !((r_v_cnt_q >= C_VS_FIRST) && (r_v_cnt_q <= C_VS_LAST));
    assign w_dec      = {w_hs_n, w_vs_n, w_vis};
    assign w_pipe_out = r_pipe_q[C_PW-1 -: 3];

    generate
        if (RENDER_LAT == 1) begin : g_pipe_single
            assign w_pipe_shift = w_dec;
        end else begin : g_pipe_multi
            assign w_pipe_shift = {r_pipe_q[C_PW-4:0], w_dec};
        end
    endgenerate

    always_comb begin
        w_phase_d       = ~r_phase_q;
        w_h_cnt_d       = r_h_cnt_q;
        w_v_cnt_d       = r_v_cnt_q;
        w_pipe_d        = r_pipe_q;
        w_hs_d          = r_hs_q;
        w_vs_d          = r_vs_q;
        w_blank_n_d     = r_blank_n_q;
        w_r_d           = r_r_q;
        w_g_d           = r_g_q;
        w_b_d           = r_b_q;
        if (w_tick) begin
            if (r_h_cnt_q == C_H_LAST) begin
                w_h_cnt_d = 10'd0;
                w_v_cnt_d = (r_v_cnt_q == C_V_LAST) ? 10'd0 : r_v_cnt_q + 10'd1;
            end else begin
                w_h_cnt_d = r_h_cnt_q + 10'd1;
            end
            w_pipe_d = w_pipe_shift;
            // Colour sampled now belongs to the position leaving the pipe now.
            w_hs_d      = w_pipe_out[2];
            w_vs_d      = w_pipe_out[1];
            w_blank_n_d = w_pipe_out[0];
            w_r_d       = w_pipe_out[0] ? PIX_R : 8'd0;
            w_g_d       = w_pipe_out[0] ? PIX_G : 8'd0;
            w_b_d       = w_pipe_out[0] ? PIX_B : 8'd0;
        end
        w_frame_start_d = w_tick && (w_h_cnt_d == 10'd0) && (w_v_cnt_d == C_V_VIS);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_phase_q       <= 1'b0;
            r_h_cnt_q       <= 10'd0;
            r_v_cnt_q       <= 10'd0;
            r_pipe_q        <= C_PIPE_RST;
            r_hs_q          <= 1'b1;
            r_vs_q          <= 1'b1;
            r_blank_n_q     <= 1'b0;
            r_frame_start_q <= 1'b0;
            r_r_q           <= 8'd0;
            r_g_q           <= 8'd0;
            r_b_q           <= 8'd0;
        end else begin
            r_phase_q       <= w_phase_d;
            r_h_cnt_q       <= w_h_cnt_d;
            r_v_cnt_q       <= w_v_cnt_d;
            r_pipe_q        <= w_pipe_d;
            r_hs_q          <= w_hs_d;
            r_vs_q          <= w_vs_d;
            r_blank_n_q     <= w_blank_n_d;
            r_frame_start_q <= w_frame_start_d;
            r_r_q           <= w_r_d;
            r_g_q           <= w_g_d;
            r_b_q           <= w_b_d;
        end
    end

    assign PIX_X       = r_h_cnt_q;
    assign PIX_Y       = r_v_cnt_q;
    assign PIX_REQ     = w_vis;
    assign FRAME_START = r_frame_start_q;
    assign VGA_CLK     = ~r_phase_q;
    assign VGA_HS      = r_hs_q;
    assign VGA_VS      = r_vs_q;
    assign VGA_BLANK_N = r_blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_r_q;
    assign VGA_G       = r_g_q;
    assign VGA_B       = r_b_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_ctrl
// Brief    : Bench for vga_scan_ctrl: full-size timing at latency 1 and 3,
//            plus a shrunken raster (latency 2) for frame-level behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scan_ctrl;

    localparam int C_HV = 64, C_HF = 8, C_HS = 16, C_HB = 8;
    localparam int C_VV = 20, C_VF = 3, C_VS = 2, C_VB = 5;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       req, fs, vclk, hs, vs, bl, sn;
        logic [7:0] r, g, b;
    } obs_t;

    int p_hv [3] = '{640, 640, C_HV};
    int p_hf [3] = '{16, 16, C_HF};
    int p_hs [3] = '{96, 96, C_HS};
    int p_hb [3] = '{48, 48, C_HB};
    int p_vv [3] = '{480, 480, C_VV};
    int p_vf [3] = '{10, 10, C_VF};
    int p_vs [3] = '{2, 2, C_VS};
    int p_vb [3] = '{33, 33, C_VB};
    int p_lat[3] = '{1, 3, 2};

    logic clk = 1'b0;
    logic rst_a_n, rst_c_n;
    logic [7:0] pr [3];
    logic [7:0] pg [3];
    logic [7:0] pb [3];

    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic       req_a, fs_a, vclk_a, hs_a, vs_a, bl_a, sn_a;
    logic       req_b, fs_b, vclk_b, hs_b, vs_b, bl_b, sn_b;
    logic       req_c, fs_c, vclk_c, hs_c, vs_c, bl_c, sn_c;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

    int   cyc [3];
    logic [23:0] smp [3];
    obs_t exp_o [3];
    int   n_chk = 0;
    int   n_err = 0;

    always #10 clk = ~clk;

    vga_scan_ctrl #(.RENDER_LAT(1)) dut_a (
        .CLOCK_50(clk), .RESET_N(rst_a_n), .PIX_X(x_a), .PIX_Y(y_a), .PIX_REQ(req_a),
        .PIX_R(pr[0]), .PIX_G(pg[0]), .PIX_B(pb[0]), .FRAME_START(fs_a), .VGA_CLK(vclk_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bl_a), .VGA_SYNC_N(sn_a),
        .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a));

    vga_scan_ctrl #(.RENDER_LAT(3)) dut_b (
        .CLOCK_50(clk), .RESET_N(rst_a_n), .PIX_X(x_b), .PIX_Y(y_b), .PIX_REQ(req_b),
        .PIX_R(pr[1]), .PIX_G(pg[1]), .PIX_B(pb[1]), .FRAME_START(fs_b), .VGA_CLK(vclk_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sn_b),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b));

    vga_scan_ctrl #(.H_VISIBLE(C_HV), .H_FRONT(C_HF), .H_SYNC(C_HS), .H_BACK(C_HB),
                    .V_VISIBLE(C_VV), .V_FRONT(C_VF), .V_SYNC(C_VS), .V_BACK(C_VB),
                    .RENDER_LAT(2)) dut_c (
        .CLOCK_50(clk), .RESET_N(rst_c_n), .PIX_X(x_c), .PIX_Y(y_c), .PIX_REQ(req_c),
        .PIX_R(pr[2]), .PIX_G(pg[2]), .PIX_B(pb[2]), .FRAME_START(fs_c), .VGA_CLK(vclk_c),
        .VGA_HS(hs_c), .VGA_VS(vs_c), .VGA_BLANK_N(bl_c), .VGA_SYNC_N(sn_c),
        .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c));

    function automatic obs_t act(input int i);
        obs_t o;
        case (i)
            0:       o = {x_a, y_a, req_a, fs_a, vclk_a, hs_a, vs_a, bl_a, sn_a, r_a, g_a, b_a};
            1:       o = {x_b, y_b, req_b, fs_b, vclk_b, hs_b, vs_b, bl_b, sn_b, r_b, g_b, b_b};
            default: o = {x_c, y_c, req_c, fs_c, vclk_c, hs_c, vs_c, bl_c, sn_c, r_c, g_c, b_c};
        endcase
        return o;
    endfunction

    function automatic obs_t rst_obs();
        obs_t e;
        e = '0;
        e.req = 1'b1; e.vclk = 1'b1; e.hs = 1'b1; e.vs = 1'b1;
        return e;
    endfunction

    function automatic int htot(input int i);
        return p_hv[i] + p_hf[i] + p_hs[i] + p_hb[i];
    endfunction

    function automatic int vtot(input int i);
        return p_vv[i] + p_vf[i] + p_vs[i] + p_vb[i];
    endfunction

    // Raster reference: cycle c since release gives c/2 ticks; the output shown after
    // tick k describes raster position k-1-latency, coloured with what was sampled at k.
    function automatic obs_t model(input int i);
        obs_t e;
        int ht, vt, k, t, p, ph, pv;
        ht = htot(i); vt = vtot(i);
        k  = cyc[i] / 2;
        t  = k % (ht * vt);
        e.x    = 10'(t % ht);
        e.y    = 10'(t / ht);
        e.req  = ((t % ht) < p_hv[i]) && ((t / ht) < p_vv[i]);
        e.vclk = (cyc[i] % 2) == 0;
        e.fs   = (cyc[i] > 0) && ((cyc[i] % 2) == 0) && (t == p_vv[i] * ht);
        e.sn   = 1'b0;
        p = k - 1 - p_lat[i];
        if (p < 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; {e.r, e.g, e.b} = 24'h0;
        end else begin
            p  = p % (ht * vt);
            ph = p % ht; pv = p / ht;
            e.hs = !(ph >= p_hv[i] + p_hf[i] && ph < p_hv[i] + p_hf[i] + p_hs[i]);
            e.vs = !(pv >= p_vv[i] + p_vf[i] && pv < p_vv[i] + p_vf[i] + p_vs[i]);
            e.bl = (ph < p_hv[i]) && (pv < p_vv[i]);
            {e.r, e.g, e.b} = e.bl ? smp[i] : 24'h0;
        end
        return e;
    endfunction

    // Renderer: during tick window k it presents the colour of position k-latency;
    // red encodes the x coordinate, blanking positions get all-ones red.
    task automatic drive(input int i);
        int ht, vt, q;
        ht = htot(i); vt = vtot(i);
        q  = cyc[i] / 2 - p_lat[i];
        pr[i] = 8'hFF;
        if (q >= 0) begin
            q = q % (ht * vt);
            if ((q % ht) < p_hv[i] && (q / ht) < p_vv[i]) pr[i] = 8'(q % ht);
        end
        pg[i] = 8'($urandom);
        pb[i] = 8'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            cyc[i] = 0; smp[i] = 24'h0; pr[i] = 8'hFF; pg[i] = 8'h0; pb[i] = 8'h0;
            exp_o[i] = model(i);
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!((i < 2) ? rst_a_n : rst_c_n)) cyc[i] = 0;
                else                                 cyc[i] = cyc[i] + 1;
                if (cyc[i] > 0 && (cyc[i] % 2) == 0) smp[i] = {pr[i], pg[i], pb[i]};
                exp_o[i] = model(i);
                if ((cyc[i] % 2) == 0) drive(i);
            end
        end
    end

    task automatic test_reset();
        obs_t o;
        rst_a_n = 1'b0; rst_c_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            o = act(i); n_chk++;
            if (o !== rst_obs()) begin
                n_err++; $display("FAIL reset_vals[%0d]: got %h expected %h", i, o, rst_obs());
            end
        end
        rst_a_n = 1'b1; rst_c_n = 1'b1;
        @(negedge clk);
        o = act(0); n_chk++;
        if ({o.x, o.vclk} !== {10'd0, 1'b0}) begin
            n_err++; $display("FAIL first_edge: got x=%0d vclk=%b expected x=0 vclk=0", o.x, o.vclk);
        end
        @(negedge clk);
        o = act(0); n_chk++;
        if ({o.x, o.y, o.vclk, o.req} !== {10'd1, 10'd0, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL first_tick: got x=%0d y=%0d vclk=%b req=%b expected x=1 y=0 vclk=1 req=1",
                              o.x, o.y, o.vclk, o.req);
        end
    endtask

    task automatic test_pix_req();
        obs_t o;
        int n = 0;
        o = act(0);
        while (o.x != 10'd639 && n < 2000) begin @(negedge clk); o = act(0); n++; end
        n_chk++;
        if ({o.x, o.req} !== {10'd639, 1'b1}) begin
            n_err++; $display("FAIL req_at_639: got x=%0d req=%b expected x=639 req=1", o.x, o.req);
        end
        repeat (2) @(negedge clk);
        o = act(0); n_chk++;
        if ({o.x, o.req} !== {10'd640, 1'b0}) begin
            n_err++; $display("FAIL req_at_640: got x=%0d req=%b expected x=640 req=0", o.x, o.req);
        end
    endtask

    task automatic test_colour(input int i);
        obs_t o;
        logic prev;
        int n = 0;
        o = act(i); prev = o.bl;
        while (!(o.bl && !prev) && n < 2000) begin
            prev = o.bl; @(negedge clk); o = act(i); n++;
        end
        n_chk++;
        if ({o.r, o.bl} !== {8'd0, 1'b1}) begin
            n_err++; $display("FAIL first_visible[%0d]: got r=%0d blank_n=%b expected r=0 blank_n=1", i, o.r, o.bl);
        end
        repeat (510) @(negedge clk);
        o = act(i); n_chk++;
        if ({o.r, o.bl} !== {8'd255, 1'b1}) begin
            n_err++; $display("FAIL pixel_255[%0d]: got r=%0d blank_n=%b expected r=255 blank_n=1", i, o.r, o.bl);
        end
        repeat (768) @(negedge clk);
        o = act(i); n_chk++;
        if ({o.r, o.bl} !== {8'd127, 1'b1}) begin
            n_err++; $display("FAIL pixel_639[%0d]: got r=%0d blank_n=%b expected r=127 blank_n=1", i, o.r, o.bl);
        end
        repeat (2) @(negedge clk);
        o = act(i); n_chk++;
        if ({o.r, o.g, o.b, o.bl} !== {24'h0, 1'b0}) begin
            n_err++; $display("FAIL blank_colour[%0d]: got rgb=%h blank_n=%b expected rgb=000000 blank_n=0",
                              i, {o.r, o.g, o.b}, o.bl);
        end
    endtask

    task automatic test_hsync(input int i);
        obs_t o;
        logic [9:0] px;
        logic ph;
        int n = 0, t0 = -1, t1 = -1, t2 = -1, t3 = -1;
        o = act(i); px = o.x; ph = o.hs;
        while (t3 < 0 && n < 6000) begin
            @(negedge clk); n++; o = act(i);
            if (t0 < 0 && o.x == 10'(p_hv[i] + p_hf[i] + 1) && px != o.x) t0 = n;
            if (t0 >= 0 && t1 < 0 && ph && !o.hs) t1 = n;
            else if (t1 >= 0 && t2 < 0 && !ph && o.hs) t2 = n;
            else if (t2 >= 0 && ph && !o.hs) t3 = n;
            px = o.x; ph = o.hs;
        end
        n_chk++;
        if (t0 < 0 || t1 - t0 != 2 * p_lat[i]) begin
            n_err++; $display("FAIL hs_delay[%0d]: got %0d cycles expected %0d", i, t1 - t0, 2 * p_lat[i]);
        end
        n_chk++;
        if (t1 < 0 || t2 - t1 != 2 * p_hs[i]) begin
            n_err++; $display("FAIL hs_width[%0d]: got %0d cycles expected %0d", i, t2 - t1, 2 * p_hs[i]);
        end
        n_chk++;
        if (t1 < 0 || t3 - t1 != 2 * htot(i)) begin
            n_err++; $display("FAIL hs_period[%0d]: got %0d cycles expected %0d", i, t3 - t1, 2 * htot(i));
        end
    endtask

    task automatic test_vsync(input int i);
        obs_t o;
        logic [9:0] py;
        logic pv;
        int n = 0, t0 = -1, t1 = -1, t2 = -1, t3 = -1;
        o = act(i); py = o.y; pv = o.vs;
        while (t3 < 0 && n < 14000) begin
            @(negedge clk); n++; o = act(i);
            if (t0 < 0 && o.y == 10'(p_vv[i] + p_vf[i]) && py != o.y) t0 = n;
            if (t0 >= 0 && t1 < 0 && pv && !o.vs) t1 = n;
            else if (t1 >= 0 && t2 < 0 && !pv && o.vs) t2 = n;
            else if (t2 >= 0 && pv && !o.vs) t3 = n;
            py = o.y; pv = o.vs;
        end
        n_chk++;
        if (t0 < 0 || t1 - t0 != 2 * (p_lat[i] + 1)) begin
            n_err++; $display("FAIL vs_delay[%0d]: got %0d cycles expected %0d", i, t1 - t0, 2 * (p_lat[i] + 1));
        end
        n_chk++;
        if (t1 < 0 || t2 - t1 != 2 * p_vs[i] * htot(i)) begin
            n_err++; $display("FAIL vs_width[%0d]: got %0d cycles expected %0d", i, t2 - t1, 2 * p_vs[i] * htot(i));
        end
        n_chk++;
        if (t1 < 0 || t3 - t1 != 2 * htot(i) * vtot(i)) begin
            n_err++; $display("FAIL vs_period[%0d]: got %0d cycles expected %0d", i, t3 - t1, 2 * htot(i) * vtot(i));
        end
    endtask

    task automatic test_frame_start(input int i);
        obs_t o;
        int cnt = 0;
        logic [19:0] pos = 'x;
        for (int c = 0; c < 2 * htot(i) * vtot(i); c++) begin
            @(negedge clk); o = act(i);
            if (o.fs) begin
                if (cnt == 0) pos = {o.x, o.y};
                cnt++;
            end
        end
        n_chk++;
        if (cnt != 1) begin
            n_err++; $display("FAIL fs_count[%0d]: got %0d pulse cycles per frame expected 1", i, cnt);
        end
        n_chk++;
        if (pos !== {10'd0, 10'(p_vv[i])}) begin
            n_err++; $display("FAIL fs_position[%0d]: got x/y=%h expected x=0 y=%0d", i, pos, p_vv[i]);
        end
    endtask

    task automatic test_reset_midframe();
        obs_t o;
        int n = 0, first = -1;
        o = act(2);
        while (!(o.x == 10'd30 && o.y == 10'd10) && n < 12000) begin @(negedge clk); o = act(2); n++; end
        #2 rst_c_n = 1'b0;
        #1 o = act(2); n_chk++;
        if (o !== rst_obs()) begin
            n_err++; $display("FAIL async_reset: got %h expected %h", o, rst_obs());
        end
        repeat (5) @(negedge clk);
        o = act(2); n_chk++;
        if (o !== rst_obs()) begin
            n_err++; $display("FAIL reset_hold: got %h expected %h", o, rst_obs());
        end
        rst_c_n = 1'b1;
        for (int c = 1; c <= 2 * C_VV * htot(2) + 100 && first < 0; c++) begin
            @(negedge clk); o = act(2);
            if (c == 2) begin
                n_chk++;
                if ({o.x, o.y} !== {10'd1, 10'd0}) begin
                    n_err++; $display("FAIL restart_pos: got x=%0d y=%0d expected x=1 y=0", o.x, o.y);
                end
            end
            if (o.fs) first = c;
        end
        n_chk++;
        if (first != 2 * C_VV * htot(2)) begin
            n_err++; $display("FAIL restart_fs: got %0d cycles expected %0d", first, 2 * C_VV * htot(2));
        end
    endtask

    task automatic test_stream(input int n);
        obs_t o;
        obs_t fo [3];
        obs_t fe [3];
        int bad [3];
        for (int i = 0; i < 3; i++) bad[i] = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                o = act(i);
                if (o !== exp_o[i]) begin
                    if (bad[i] == 0) begin fo[i] = o; fe[i] = exp_o[i]; end
                    bad[i]++;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (bad[i] != 0) begin
                n_err++;
                $display("FAIL stream[%0d]: %0d bad cycles, first got %h expected %h", i, bad[i], fo[i], fe[i]);
            end
        end
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_c_n = 1'b0;
        test_reset();
        test_pix_req();
        test_colour(0);
        test_colour(1);
        test_hsync(0);
        test_hsync(1);
        test_stream(2000);
        test_vsync(2);
        test_frame_start(2);
        test_reset_midframe();
        test_stream(6000);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
